// File: rtl/wishbone_mem_master_pkg.sv
// Shared definitions for the Wishbone burst memory master.
// Holds the FSM state encoding and the byte-select constant used for
// full-word transfers.
package wb_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_BUS     = 3'd2,
    ST_DELIVER = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // Every transfer moves a full 32-bit word.
  localparam logic [3:0] SEL_ALL = 4'hF;

endpackage

// File: rtl/wishbone_mem_master_if.sv
// Wishbone bus bundle between the burst master and the memory interconnect.
// Signals:
//   m_we_o, m_cyc_o, m_stb_o : master controls
//   m_sel_o[3:0]             : byte selects
//   m_adr_o[31:0]            : word address
//   m_dat_o[31:0]            : write data
//   m_dat_i[31:0]            : read data from interconnect
//   m_ack_i                  : transfer acknowledge from interconnect
// Modports: master (drives controls/address/data), slave (drives ack/read data).
interface wishbone_mem_master_if;

  logic        m_we_o;
  logic        m_cyc_o;
  logic        m_stb_o;
  logic [3:0]  m_sel_o;
  logic [31:0] m_adr_o;
  logic [31:0] m_dat_o;
  logic [31:0] m_dat_i;
  logic        m_ack_i;

  modport master (
    output m_we_o, m_cyc_o, m_stb_o, m_sel_o, m_adr_o, m_dat_o,
    input  m_dat_i, m_ack_i
  );

  modport slave (
    input  m_we_o, m_cyc_o, m_stb_o, m_sel_o, m_adr_o, m_dat_o,
    output m_dat_i, m_ack_i
  );

endinterface

// File: rtl/wb_ack_timer.sv
// Ack-wait timer for the Wishbone burst master.
// Counts clock cycles while 'run' is high and restarts from zero whenever
// 'run' is low, so every entry into the bus phase gets a fresh budget.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   run       : high while the master waits for an ack
//   expired   : high in the TIMEOUT-th consecutive waiting cycle
module wb_ack_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !run) cnt <= '0;
    else             cnt <= cnt + W'(1);
  end

  // Flagging on TIMEOUT-1 lets the master drop cyc at the end of exactly
  // TIMEOUT waiting cycles.
  assign expired = run && (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/wishbone_mem_master.sv
// Wishbone burst memory master.
// Accepts a command (direction, start word address, word count) and moves
// that many words between a streaming source/sink and a Wishbone slave,
// one single transfer per cyc assertion.
// Optional feature: define WB_MASTER_TIMEOUT_EN to abort a burst with
// cmd_err=1 when an ack does not arrive within TIMEOUT cycles.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   cmd_stb/cmd_we/cmd_adr/cmd_count  : command start, direction, address, length
//   cmd_busy/cmd_done/cmd_err         : command status
//   wr_dat/wr_stb/wr_rdy              : write-data source handshake
//   rd_dat/rd_stb/rd_rdy              : read-data sink handshake
//   wb                                : Wishbone master bundle
module wishbone_mem_master
  import wb_master_pkg::*;
#(
  parameter logic [31:0] ADDR_INC = 32'd1,
  parameter int          TIMEOUT  = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_stb,
  input  logic                          cmd_we,
  input  logic [31:0]                   cmd_adr,
  input  logic [15:0]                   cmd_count,
  output logic                          cmd_busy,
  output logic                          cmd_done,
  output logic                          cmd_err,
  input  logic [31:0]                   wr_dat,
  input  logic                          wr_stb,
  output logic                          wr_rdy,
  output logic [31:0]                   rd_dat,
  output logic                          rd_stb,
  input  logic                          rd_rdy,
  wishbone_mem_master_if.master         wb
);

  state_e      state;
  logic        we_q;
  logic [15:0] remain;
  logic        last_word;

  assign last_word = (remain == 16'd1);

`ifdef WB_MASTER_TIMEOUT_EN
  logic ack_timeout;

  wb_ack_timer #(.TIMEOUT(TIMEOUT)) u_ack_timer (
    .clk     (clk),
    .rst     (rst),
    .run     (state == ST_BUS),
    .expired (ack_timeout)
  );
`else
  assign cmd_err = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      we_q        <= 1'b0;
      remain      <= '0;
      cmd_busy    <= 1'b0;
      cmd_done    <= 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
      cmd_err     <= 1'b0;
`endif
      wr_rdy      <= 1'b0;
      rd_dat      <= '0;
      rd_stb      <= 1'b0;
      wb.m_we_o   <= 1'b0;
      wb.m_cyc_o  <= 1'b0;
      wb.m_stb_o  <= 1'b0;
      wb.m_sel_o  <= '0;
      wb.m_adr_o  <= '0;
      wb.m_dat_o  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_stb) begin
            we_q       <= cmd_we;
            remain     <= cmd_count;
            wb.m_adr_o <= cmd_adr;
            cmd_busy   <= 1'b1;
`ifdef WB_MASTER_TIMEOUT_EN
            cmd_err    <= 1'b0;
`endif
            if (cmd_count == 16'd0) begin
              state    <= ST_DONE;
              cmd_done <= 1'b1;
            end else if (cmd_we) begin
              state  <= ST_FETCH;
              wr_rdy <= 1'b1;
            end else begin
              // Reads start the bus cycle straight from IDLE.
              state      <= ST_BUS;
              wb.m_cyc_o <= 1'b1;
              wb.m_stb_o <= 1'b1;
              wb.m_we_o  <= 1'b0;
              wb.m_sel_o <= SEL_ALL;
            end
          end
        end

        ST_FETCH: begin
          if (wr_stb) begin
            wb.m_dat_o <= wr_dat;
            wr_rdy     <= 1'b0;
            state      <= ST_BUS;
            wb.m_cyc_o <= 1'b1;
            wb.m_stb_o <= 1'b1;
            wb.m_we_o  <= we_q;
            wb.m_sel_o <= SEL_ALL;
          end
        end

        ST_BUS: begin
          if (wb.m_ack_i) begin
            wb.m_cyc_o <= 1'b0;
            wb.m_stb_o <= 1'b0;
            wb.m_we_o  <= 1'b0;
            wb.m_sel_o <= '0;
            if (we_q) begin
              // A write word is complete on ack.
              remain     <= remain - 16'd1;
              wb.m_adr_o <= wb.m_adr_o + ADDR_INC;
              if (last_word) begin
                state    <= ST_DONE;
                cmd_done <= 1'b1;
              end else begin
                state  <= ST_FETCH;
                wr_rdy <= 1'b1;
              end
            end else begin
              rd_dat <= wb.m_dat_i;
              rd_stb <= 1'b1;
              state  <= ST_DELIVER;
            end
          end
`ifdef WB_MASTER_TIMEOUT_EN
          else if (ack_timeout) begin
            wb.m_cyc_o <= 1'b0;
            wb.m_stb_o <= 1'b0;
            wb.m_we_o  <= 1'b0;
            wb.m_sel_o <= '0;
            cmd_err    <= 1'b1;
            cmd_done   <= 1'b1;
            state      <= ST_DONE;
          end
`endif
        end

        ST_DELIVER: begin
          // rd_dat is not touched here, so it stays stable while the sink stalls.
          if (rd_rdy) begin
            rd_stb     <= 1'b0;
            remain     <= remain - 16'd1;
            wb.m_adr_o <= wb.m_adr_o + ADDR_INC;
            if (last_word) begin
              state    <= ST_DONE;
              cmd_done <= 1'b1;
            end else begin
              state      <= ST_BUS;
              wb.m_cyc_o <= 1'b1;
              wb.m_stb_o <= 1'b1;
              wb.m_sel_o <= SEL_ALL;
            end
          end
        end

        ST_DONE: begin
          cmd_done <= 1'b0;
          cmd_busy <= 1'b0;
          state    <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_mem_master.sv
// Directed testbench for wishbone_mem_master.
// Inputs change and outputs are sampled on the falling clock edge.
// Build with WB_MASTER_TIMEOUT_EN defined to also exercise the ack timeout.
module tb_wishbone_mem_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_stb, cmd_we;
  logic [31:0] cmd_adr;
  logic [15:0] cmd_count;
  logic        cmd_busy, cmd_done, cmd_err;
  logic [31:0] wr_dat;
  logic        wr_stb, wr_rdy;
  logic [31:0] rd_dat;
  logic        rd_stb, rd_rdy;

  int n_vec  = 0;
  int n_err  = 0;
  int n_done = 0;

  wishbone_mem_master_if wb ();

  wishbone_mem_master #(
    .ADDR_INC (32'd1),
    .TIMEOUT  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_stb   (cmd_stb),
    .cmd_we    (cmd_we),
    .cmd_adr   (cmd_adr),
    .cmd_count (cmd_count),
    .cmd_busy  (cmd_busy),
    .cmd_done  (cmd_done),
    .cmd_err   (cmd_err),
    .wr_dat    (wr_dat),
    .wr_stb    (wr_stb),
    .wr_rdy    (wr_rdy),
    .rd_dat    (rd_dat),
    .rd_stb    (rd_stb),
    .rd_rdy    (rd_rdy),
    .wb        (wb.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one cycle; also counts completion pulses seen.
  task automatic tick();
    @(negedge clk);
    if (cmd_done) n_done++;
  endtask

  task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [15:0] cnt);
    cmd_stb   = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_count = cnt;
    tick();
    cmd_stb   = 1'b0;
  endtask

  // Slave side of one transfer: wait for stb, check it, ack one cycle later.
  task automatic slave_word(input logic [31:0] adr, input logic we,
                            input logic [31:0] wdat, input logic [31:0] rdat);
    int k = 0;
    while (!wb.m_stb_o && k < 40) begin
      tick();
      k++;
    end
    check("stb_seen", 32'(wb.m_stb_o), 32'd1);
    check("cyc",      32'(wb.m_cyc_o), 32'd1);
    check("adr",      wb.m_adr_o, adr);
    check("we",       32'(wb.m_we_o), 32'(we));
    check("sel",      32'(wb.m_sel_o), 32'hF);
    if (we) check("wdat", wb.m_dat_o, wdat);
    tick();
    check("stb_hold", 32'(wb.m_stb_o), 32'd1);
    wb.m_ack_i = 1'b1;
    wb.m_dat_i = rdat;
    tick();
    wb.m_ack_i = 1'b0;
    wb.m_dat_i = '0;
    check("cyc_drop", 32'(wb.m_cyc_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rst = 1'b1; cmd_stb = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_count = '0;
    wr_dat = '0; wr_stb = 1'b0; rd_rdy = 1'b0;
    wb.m_ack_i = 1'b0; wb.m_dat_i = '0;
    tick(); tick();

    // Reset state
    check("rst_cyc",  32'(wb.m_cyc_o), 32'd0);
    check("rst_stb",  32'(wb.m_stb_o), 32'd0);
    check("rst_we",   32'(wb.m_we_o), 32'd0);
    check("rst_sel",  32'(wb.m_sel_o), 32'd0);
    check("rst_adr",  wb.m_adr_o, 32'd0);
    check("rst_dat",  wb.m_dat_o, 32'd0);
    check("rst_flags", {26'd0, wr_rdy, rd_stb, cmd_busy, cmd_done, cmd_err, 1'b0}, 32'd0);
    check("rst_rdat", rd_dat, 32'd0);
    rst = 1'b0;
    tick();

    // Write burst: 0x10..0x12 with 0xA1..0xA3
    d0 = n_done;
    send_cmd(1'b1, 32'h10, 16'd3);
    check("wr_busy", 32'(cmd_busy), 32'd1);
    check("wr_rdy0", 32'(wr_rdy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      wr_dat = 32'hA1 + 32'(i);
      wr_stb = 1'b1;
      tick();
      wr_stb = 1'b0;
      check("wr_rdy_drop", 32'(wr_rdy), 32'd0);
      slave_word(32'h10 + 32'(i), 1'b1, 32'hA1 + 32'(i), 32'h0);
      if (i < 2) check("wr_rdy_next", 32'(wr_rdy), 32'd1);
    end
    check("wr_done", 32'(cmd_done), 32'd1);
    check("wr_err",  32'(cmd_err), 32'd0);
    tick();
    check("wr_done_once", 32'(n_done - d0), 32'd1);
    check("wr_idle_busy", 32'(cmd_busy), 32'd0);
    check("wr_idle_done", 32'(cmd_done), 32'd0);

    // Read burst with sink stall, stray ack and ignored command
    rd_rdy = 1'b0;
    send_cmd(1'b0, 32'h20, 16'd2);
    check("rd_latency", 32'(wb.m_stb_o), 32'd1);
    slave_word(32'h20, 1'b0, 32'h0, 32'hDEAD0001);
    for (int s = 0; s < 3; s++) begin
      check("rd_stall_stb", 32'(rd_stb), 32'd1);
      check("rd_stall_dat", rd_dat, 32'hDEAD0001);
      if (s == 0) begin
        wb.m_ack_i = 1'b1;
        wb.m_dat_i = 32'h55555555;
        cmd_stb = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h99; cmd_count = 16'd1;
      end
      tick();
      wb.m_ack_i = 1'b0;
      wb.m_dat_i = '0;
      cmd_stb = 1'b0;
    end
    check("rd_stray_ack_dat", rd_dat, 32'hDEAD0001);
    check("rd_stray_ack_cyc", 32'(wb.m_cyc_o), 32'd0);
    check("rd_busy_ignore", {31'd0, wr_rdy}, 32'd0);
    rd_rdy = 1'b1;
    tick();
    rd_rdy = 1'b0;
    check("rd_stb_drop", 32'(rd_stb), 32'd0);
    slave_word(32'h21, 1'b0, 32'h0, 32'hDEAD0002);
    check("rd_w2_stb", 32'(rd_stb), 32'd1);
    check("rd_w2_dat", rd_dat, 32'hDEAD0002);
    rd_rdy = 1'b1;
    tick();
    rd_rdy = 1'b0;
    check("rd_done", 32'(cmd_done), 32'd1);
    check("rd_err",  32'(cmd_err), 32'd0);
    tick();

    // Address wrap at 0xFFFFFFFF
    rd_rdy = 1'b1;
    send_cmd(1'b0, 32'hFFFFFFFF, 16'd2);
    slave_word(32'hFFFFFFFF, 1'b0, 32'h0, 32'h11);
    check("wrap_d1", rd_dat, 32'h11);
    tick();
    slave_word(32'h00000000, 1'b0, 32'h0, 32'h22);
    check("wrap_d2", rd_dat, 32'h22);
    tick();
    check("wrap_done", 32'(cmd_done), 32'd1);
    tick();

    // Zero-length command, plus a strobe while still busy
    send_cmd(1'b0, 32'h30, 16'd0);
    check("zero_done", 32'(cmd_done), 32'd1);
    check("zero_busy", 32'(cmd_busy), 32'd1);
    check("zero_cyc",  32'(wb.m_cyc_o), 32'd0);
    send_cmd(1'b0, 32'h30, 16'd5);
    check("zero_done_end", 32'(cmd_done), 32'd0);
    check("zero_busy_end", 32'(cmd_busy), 32'd0);
    tick();
    check("zero_ignored_cyc",  32'(wb.m_cyc_o), 32'd0);
    check("zero_ignored_busy", 32'(cmd_busy), 32'd0);

    // Reset during the bus phase of word 2 of 4
    d0 = n_done;
    rd_rdy = 1'b1;
    send_cmd(1'b0, 32'h40, 16'd4);
    slave_word(32'h40, 1'b0, 32'h0, 32'h1);
    tick();
    check("rst_mid_stb", 32'(wb.m_stb_o), 32'd1);
    check("rst_mid_adr", wb.m_adr_o, 32'h41);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_cyc",  32'(wb.m_cyc_o), 32'd0);
    check("rst_mid_busy", 32'(cmd_busy), 32'd0);
    check("rst_mid_done", 32'(cmd_done), 32'd0);
    check("rst_mid_rstb", 32'(rd_stb), 32'd0);
    tick(); tick(); tick();
    check("rst_mid_nodone", 32'(n_done - d0), 32'd0);
    check("rst_mid_idle",   32'(wb.m_cyc_o), 32'd0);
    rd_rdy = 1'b0;

`ifdef WB_MASTER_TIMEOUT_EN
    // Ack never arrives: cyc held exactly TIMEOUT=8 cycles, then error
    begin
      int k = 0;
      send_cmd(1'b0, 32'h80, 16'd3);
      while (wb.m_cyc_o && k < 50) begin
        k++;
        tick();
      end
      check("to_cycles", 32'(k), 32'd8);
      check("to_done", 32'(cmd_done), 32'd1);
      check("to_err",  32'(cmd_err), 32'd1);
      tick();
      check("to_busy", 32'(cmd_busy), 32'd0);
      check("to_cyc",  32'(wb.m_cyc_o), 32'd0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wishbone_mem_master.md
WISHBONE_MEM_MASTER -- requirements
Module: wishbone_mem_master

Interface
REQ-001 SHALL have parameter ADDR_INC, default 1: address increment per word transferred.
REQ-002 SHALL have parameter TIMEOUT, default 1024: ack-wait cycle limit, used only with the timeout feature.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port cmd_stb, input, 1: one-cycle command start strobe.
REQ-006 SHALL have port cmd_we, input, 1: 1 = write burst, 0 = read burst.
REQ-007 SHALL have port cmd_adr, input, 32: start word address.
REQ-008 SHALL have port cmd_count, input, 16: words to transfer.
REQ-009 SHALL have port cmd_busy, output, 1: high from command accept until return to IDLE.
REQ-010 SHALL have port cmd_done, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port cmd_err, output, 1: valid with cmd_done; 1 = aborted.
REQ-012 SHALL have port wr_dat, input, 32: write data from source.
REQ-013 SHALL have port wr_stb, input, 1: wr_dat valid.
REQ-014 SHALL have port wr_rdy, output, 1: word taken this cycle when wr_stb & wr_rdy.
REQ-015 SHALL have port rd_dat, output, 32: read data to sink.
REQ-016 SHALL have port rd_stb, output, 1: rd_dat valid.
REQ-017 SHALL have port rd_rdy, input, 1: sink accepts when rd_stb & rd_rdy.
REQ-018 SHALL have ports m_we_o, m_cyc_o, m_stb_o, output, 1 each: Wishbone master controls toward the memory interconnect.
REQ-019 SHALL have ports m_sel_o output 4, m_adr_o output 32, m_dat_o output 32: byte selects, address, write data.
REQ-020 SHALL have ports m_dat_i input 32, m_ack_i input 1: read data and ack from interconnect.

Function
REQ-021 SHALL implement FSM states IDLE, FETCH, BUS, DELIVER, DONE; all outputs registered.
REQ-022 IDLE: cmd_stb latches cmd_we/cmd_adr/cmd_count; next state BUS (read) or FETCH (write); cmd_count=0 goes directly to DONE with no bus cycle; cmd_stb while busy SHALL be ignored.
REQ-023 FETCH: wr_rdy=1; on wr_stb latch wr_dat into m_dat_o, wr_rdy=0 next cycle, go BUS.
REQ-024 BUS: m_cyc_o=m_stb_o=1, m_sel_o=4'hF, m_we_o=latched cmd_we, m_adr_o=current address; held until m_ack_i; cyc/stb drop the cycle after ack (one transfer per cyc).
REQ-025 Read ack: capture m_dat_i into rd_dat, go DELIVER; rd_stb=1 held with stable rd_dat until rd_rdy.
REQ-026 After each completed word: remaining count decrements, address += ADDR_INC modulo 2^32 (0xFFFFFFFF wraps to 0x00000000); count 0 -> DONE, else FETCH/BUS.
REQ-027 DONE: cmd_done=1 one cycle, cmd_err per abort status, cmd_busy drops same cycle as return to IDLE.
REQ-028 m_ack_i outside BUS SHALL be ignored; latency cmd_stb (read) to m_stb_o high = 1 cycle.

Reset
REQ-029 rst SHALL force IDLE mid-burst; outputs 0: m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o, wr_rdy, rd_stb, rd_dat, cmd_busy, cmd_done, cmd_err; no completion pulse emitted.

Configuration
REQ-030 With WB_MASTER_TIMEOUT_EN defined: counter restarts on BUS entry; TIMEOUT cycles without ack drops cyc/stb, abandons remaining words, DONE with cmd_err=1.
REQ-031 Without WB_MASTER_TIMEOUT_EN: BUS waits indefinitely; cmd_err tied 0; no counter logic.

Structure
REQ-032 Package wb_master_pkg SHALL hold FSM state encoding and constant SEL_ALL=4'hF.
REQ-033 Timeout counter SHALL be sub-module wb_ack_timer, instantiated only under WB_MASTER_TIMEOUT_EN.

Verification
REQ-034 Write burst adr=0x10, count=3, data 0xA1,0xA2,0xA3, ack 1 cycle after stb -> writes to 0x10,0x11,0x12, one cmd_done, cmd_err=0.
REQ-035 Read burst adr=0x20, count=2, slave returns 0xDEAD0001/0xDEAD0002, rd_rdy low 3 cycles -> rd_dat stable while stalled, both words in order.
REQ-036 Read adr=0xFFFFFFFF, count=2 -> second m_adr_o = 0x00000000.
REQ-037 count=0 -> cmd_done next cycle, m_cyc_o never asserted; cmd_stb while busy -> ignored.
REQ-038 rst asserted during BUS of word 2 of 4 -> next cycle m_cyc_o=0, cmd_busy=0, no cmd_done.
REQ-039 WB_MASTER_TIMEOUT_EN, TIMEOUT=8, ack never asserted -> cyc drops after 8 cycles, cmd_done=1, cmd_err=1.
